// File: rtl/wb_arb_pkg.sv
// Shared definitions for the three-master Wishbone arbiter: FSM encoding,
// burst cycle-type codes and the master count.
package wb_arb_pkg;
   localparam int NUM_M = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TMO  = 2'd2
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   // Reset value of the last grantee: master 2, so master 0 is served first.
   localparam logic [NUM_M-1:0] LAST_RST = 3'b100;
endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin selector: the first requester found when
// scanning upward from the master after the last grantee wins.
module wb_arb_rr_pick
   import wb_arb_pkg::*;
(
   input  logic [NUM_M-1:0] req,
   input  logic [NUM_M-1:0] last,
   output logic [NUM_M-1:0] gnt
);

   // Walk distances from farthest to nearest so the nearest requester is written last.
   always_comb begin
      gnt = '0;
      for (int k = NUM_M; k >= 1; k--) begin
         for (int i = 0; i < NUM_M; i++) begin
            if (last[i] && req[(i + k) % NUM_M]) begin
               gnt                    = '0;
               gnt[(i + k) % NUM_M]   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_arb3.sv
// Three-master to one-slave Wishbone arbiter with round-robin grant held for
// the whole cycle and a stall watchdog that terminates hung cycles with err.
module wb_arb3
   import wb_arb_pkg::*;
#(
   parameter int dw        = 32,
   parameter int aw        = 32,
   parameter int to_cycles = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [aw-1:0]   wbm0_adr_i,
   input  logic [dw-1:0]   wbm0_dat_i,
   input  logic [dw/8-1:0] wbm0_sel_i,
   input  logic            wbm0_cyc_i,
   input  logic            wbm0_stb_i,
   input  logic            wbm0_we_i,
   input  logic [2:0]      wbm0_cti_i,
   input  logic [1:0]      wbm0_bte_i,
   output logic            wbm0_ack_o,
   output logic            wbm0_err_o,
   output logic            wbm0_rty_o,
   output logic [dw-1:0]   wbm0_dat_o,
   input  logic [aw-1:0]   wbm1_adr_i,
   input  logic [dw-1:0]   wbm1_dat_i,
   input  logic [dw/8-1:0] wbm1_sel_i,
   input  logic            wbm1_cyc_i,
   input  logic            wbm1_stb_i,
   input  logic            wbm1_we_i,
   input  logic [2:0]      wbm1_cti_i,
   input  logic [1:0]      wbm1_bte_i,
   output logic            wbm1_ack_o,
   output logic            wbm1_err_o,
   output logic            wbm1_rty_o,
   output logic [dw-1:0]   wbm1_dat_o,
   input  logic [aw-1:0]   wbm2_adr_i,
   input  logic [dw-1:0]   wbm2_dat_i,
   input  logic [dw/8-1:0] wbm2_sel_i,
   input  logic            wbm2_cyc_i,
   input  logic            wbm2_stb_i,
   input  logic            wbm2_we_i,
   input  logic [2:0]      wbm2_cti_i,
   input  logic [1:0]      wbm2_bte_i,
   output logic            wbm2_ack_o,
   output logic            wbm2_err_o,
   output logic            wbm2_rty_o,
   output logic [dw-1:0]   wbm2_dat_o,
   output logic [aw-1:0]   wbs_adr_o,
   output logic [dw-1:0]   wbs_dat_o,
   output logic [dw/8-1:0] wbs_sel_o,
   output logic            wbs_cyc_o,
   output logic            wbs_stb_o,
   output logic            wbs_we_o,
   output logic [2:0]      wbs_cti_o,
   output logic [1:0]      wbs_bte_o,
   input  logic [dw-1:0]   wbs_dat_i,
   input  logic            wbs_ack_i,
   input  logic            wbs_err_i,
   input  logic            wbs_rty_i,
   output logic [2:0]      gnt_o
);

   localparam int              CW  = (to_cycles > 0) ? $clog2(to_cycles + 1) : 1;
   localparam logic [CW-1:0]   LIM = (to_cycles > 0) ? CW'(to_cycles - 1) : '0;

   logic [NUM_M-1:0][aw-1:0]   m_adr;
   logic [NUM_M-1:0][dw-1:0]   m_dat;
   logic [NUM_M-1:0][dw/8-1:0] m_sel;
   logic [NUM_M-1:0][2:0]      m_cti;
   logic [NUM_M-1:0][1:0]      m_bte;
   logic [NUM_M-1:0]           m_cyc, m_stb, m_we;
   logic [NUM_M-1:0]           m_ack, m_err, m_rty;

   arb_state_t       state;
   logic [NUM_M-1:0] gnt, last, pick, msel;
   logic [CW-1:0]    cnt;
   logic             rst_hold;
   logic             busy, g_cyc, g_stb, g_we, term, tmo_hit;
   logic [dw/8-1:0]  sel_mux;

   assign m_adr = {wbm2_adr_i, wbm1_adr_i, wbm0_adr_i};
   assign m_dat = {wbm2_dat_i, wbm1_dat_i, wbm0_dat_i};
   assign m_sel = {wbm2_sel_i, wbm1_sel_i, wbm0_sel_i};
   assign m_cti = {wbm2_cti_i, wbm1_cti_i, wbm0_cti_i};
   assign m_bte = {wbm2_bte_i, wbm1_bte_i, wbm0_bte_i};
   assign m_cyc = {wbm2_cyc_i, wbm1_cyc_i, wbm0_cyc_i};
   assign m_stb = {wbm2_stb_i, wbm1_stb_i, wbm0_stb_i};
   assign m_we  = {wbm2_we_i,  wbm1_we_i,  wbm0_we_i};

   wb_arb_rr_pick u_pick (
      .req  (m_cyc),
      .last (last),
      .gnt  (pick)
   );

   // Reset gating keeps every strobe and termination quiet the instant reset rises.
   assign busy  = (state == BUSY) && !wb_rst_i;
   assign g_cyc = |(gnt & m_cyc);
   assign g_stb = |(gnt & m_stb);
   assign g_we  = |(gnt & m_we);
   assign term  = wbs_ack_i | wbs_err_i | wbs_rty_i;

   generate
      if (to_cycles > 0) begin : g_wd
         assign tmo_hit = busy && g_cyc && g_stb && !term && (cnt == LIM);
      end else begin : g_nowd
         assign tmo_hit = 1'b0;
      end
   endgenerate

   // Address/data path stays on the last grantee while no one holds the bus.
   assign msel = (gnt != '0) ? gnt : last;

   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      sel_mux   = '0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (msel[i]) begin
            wbs_adr_o = m_adr[i];
            wbs_dat_o = m_dat[i];
            sel_mux   = m_sel[i];
            wbs_cti_o = m_cti[i];
            wbs_bte_o = m_bte[i];
         end
      end
   end

   assign wbs_cyc_o = busy && g_cyc;
   assign wbs_stb_o = busy && g_stb;
   assign wbs_we_o  = busy && g_we;
   assign wbs_sel_o = busy ? sel_mux : '0;

   assign m_ack = busy ? (gnt & {NUM_M{wbs_ack_i}})           : '0;
   assign m_err = busy ? (gnt & {NUM_M{wbs_err_i | tmo_hit}}) : '0;
   assign m_rty = busy ? (gnt & {NUM_M{wbs_rty_i}})           : '0;

   assign {wbm2_ack_o, wbm1_ack_o, wbm0_ack_o} = m_ack;
   assign {wbm2_err_o, wbm1_err_o, wbm0_err_o} = m_err;
   assign {wbm2_rty_o, wbm1_rty_o, wbm0_rty_o} = m_rty;
   assign wbm0_dat_o = wbs_dat_i;
   assign wbm1_dat_o = wbs_dat_i;
   assign wbm2_dat_o = wbs_dat_i;
   assign gnt_o      = gnt;

   // rst_hold spends the first edge after reset so grants start on the second.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         gnt      <= '0;
         last     <= LAST_RST;
         cnt      <= '0;
         rst_hold <= 1'b1;
      end else begin
         rst_hold <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (!rst_hold && (m_cyc != '0)) begin
                  gnt   <= pick;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (!g_cyc) begin
                  state <= IDLE;
                  last  <= gnt;
                  gnt   <= '0;
                  cnt   <= '0;
               end else if (tmo_hit) begin
                  state <= TMO;
                  cnt   <= '0;
               end else if (g_stb && !term) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
               end
            end
            TMO: begin
               if (!g_cyc) begin
                  state <= IDLE;
                  last  <= gnt;
                  gnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arb3.sv
// Bench for wb_arb3: directed vector table, hand sequences for watchdog and
// reset corners, then random traffic against a cycle-level reference model.
module tb_wb_arb3;
   import wb_arb_pkg::*;

   localparam int          TO = 8;
   localparam logic [31:0] A0 = 32'h100, A1 = 32'h010, A2 = 32'h200;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   always #5 wb_clk_i = ~wb_clk_i;

   logic [2:0]  cyc, stb, we;
   logic [31:0] adr [3];
   logic [31:0] dat [3];
   logic [3:0]  sel [3];
   logic [2:0]  cti [3];
   logic [1:0]  bte [3];
   logic [31:0] s_dat;
   logic        s_ack, s_err, s_rty;

   wire [2:0]   ack, err, rty, gnt;
   wire [31:0]  mdat0, mdat1, mdat2, wbs_adr, wbs_dat;
   wire [3:0]   wbs_sel;
   wire         wbs_cyc, wbs_stb, wbs_we;
   wire [2:0]   wbs_cti;
   wire [1:0]   wbs_bte;

   wb_arb3 #(.dw(32), .aw(32), .to_cycles(TO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbm0_adr_i(adr[0]), .wbm0_dat_i(dat[0]), .wbm0_sel_i(sel[0]), .wbm0_cyc_i(cyc[0]),
      .wbm0_stb_i(stb[0]), .wbm0_we_i(we[0]), .wbm0_cti_i(cti[0]), .wbm0_bte_i(bte[0]),
      .wbm0_ack_o(ack[0]), .wbm0_err_o(err[0]), .wbm0_rty_o(rty[0]), .wbm0_dat_o(mdat0),
      .wbm1_adr_i(adr[1]), .wbm1_dat_i(dat[1]), .wbm1_sel_i(sel[1]), .wbm1_cyc_i(cyc[1]),
      .wbm1_stb_i(stb[1]), .wbm1_we_i(we[1]), .wbm1_cti_i(cti[1]), .wbm1_bte_i(bte[1]),
      .wbm1_ack_o(ack[1]), .wbm1_err_o(err[1]), .wbm1_rty_o(rty[1]), .wbm1_dat_o(mdat1),
      .wbm2_adr_i(adr[2]), .wbm2_dat_i(dat[2]), .wbm2_sel_i(sel[2]), .wbm2_cyc_i(cyc[2]),
      .wbm2_stb_i(stb[2]), .wbm2_we_i(we[2]), .wbm2_cti_i(cti[2]), .wbm2_bte_i(bte[2]),
      .wbm2_ack_o(ack[2]), .wbm2_err_o(err[2]), .wbm2_rty_o(rty[2]), .wbm2_dat_o(mdat2),
      .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_dat), .wbs_sel_o(wbs_sel), .wbs_cyc_o(wbs_cyc),
      .wbs_stb_o(wbs_stb), .wbs_we_o(wbs_we), .wbs_cti_o(wbs_cti), .wbs_bte_o(wbs_bte),
      .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .gnt_o(gnt)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge wb_clk_i);
      #1;
   endtask

   function automatic logic [1:0] ix(input int v);
      return 2'(v);
   endfunction

   typedef struct {
      logic        rst;
      logic [2:0]  cyc;
      logic        ack;
      logic [2:0]  cti2;
      logic [2:0]  e_gnt;
      logic [2:0]  e_ack;
      logic        e_cyc;
      logic [31:0] e_adr;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input logic r, input logic [2:0] c, input logic a, input logic [2:0] t2,
                      input logic [2:0] g, input logic [2:0] ea, input logic ec, input logic [31:0] ead);
      vec_t v;
      v.rst = r; v.cyc = c; v.ack = a; v.cti2 = t2;
      v.e_gnt = g; v.e_ack = ea; v.e_cyc = ec; v.e_adr = ead;
      tbl.push_back(v);
   endtask

   // Reference model state: mode 0 idle, 1 owning the slave, 2 timed out.
   int   mode, gi, li, cnt;
   logic hold, m_tmo, m_term;

   task automatic mdl_reset();
      mode = 0; gi = 0; li = 2; cnt = 0; hold = 1'b1;
   endtask

   task automatic mdl_step();
      logic was_hold;
      was_hold = hold;
      hold     = 1'b0;
      case (mode)
         0: if (!was_hold && cyc != 3'b000) begin
               for (int k = 3; k >= 1; k--)
                  if (cyc[ix((li + k) % 3)]) gi = (li + k) % 3;
               mode = 1;
               cnt  = 0;
            end
         1: if (!cyc[ix(gi)]) begin
               mode = 0; li = gi; cnt = 0;
            end else if (m_tmo) begin
               mode = 2; cnt = 0;
            end else if (stb[ix(gi)] && !m_term) cnt++;
            else cnt = 0;
         default: if (!cyc[ix(gi)]) begin
               mode = 0; li = gi;
            end
      endcase
   endtask

   initial begin
      logic       rst_now, busy, quiet;
      logic [2:0] oh, e_gnt, e_ack, e_err, e_rty, e_ctl;
      logic [3:0] e_sel;
      int         ttl [3];
      int         src, r, p;

      cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 32'hcafe_f00d;
      adr[0] = A0; adr[1] = A1; adr[2] = A2;
      for (int i = 0; i < 3; i++) begin
         dat[i] = 32'h1111_0000 + 32'(i); sel[i] = 4'hf; cti[i] = CTI_CLASSIC; bte[i] = 2'b00; ttl[i] = 0;
      end

      // Single m1 classic read, then round-robin with all three requesting,
      // then an m2 incrementing burst with m0 waiting.
      add(1'b1, 3'b000, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b010, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b010, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b010, 1'b1, CTI_CLASSIC, 3'b010, 3'b010, 1'b1, A1);
      add(1'b0, 3'b000, 1'b0, CTI_CLASSIC, 3'b010, 3'b000, 1'b0, A1);
      add(1'b0, 3'b000, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A1);
      add(1'b1, 3'b000, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b111, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b111, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b111, 1'b1, CTI_CLASSIC, 3'b001, 3'b001, 1'b1, A0);
      add(1'b0, 3'b110, 1'b0, CTI_CLASSIC, 3'b001, 3'b000, 1'b0, A0);
      add(1'b0, 3'b111, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A0);
      add(1'b0, 3'b111, 1'b1, CTI_CLASSIC, 3'b010, 3'b010, 1'b1, A1);
      add(1'b0, 3'b101, 1'b0, CTI_CLASSIC, 3'b010, 3'b000, 1'b0, A1);
      add(1'b0, 3'b111, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A1);
      add(1'b0, 3'b111, 1'b1, CTI_CLASSIC, 3'b100, 3'b100, 1'b1, A2);
      add(1'b0, 3'b011, 1'b0, CTI_CLASSIC, 3'b100, 3'b000, 1'b0, A2);
      add(1'b0, 3'b111, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b111, 1'b1, CTI_CLASSIC, 3'b001, 3'b001, 1'b1, A0);
      add(1'b0, 3'b000, 1'b0, CTI_CLASSIC, 3'b001, 3'b000, 1'b0, A0);
      add(1'b0, 3'b000, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A0);
      add(1'b0, 3'b100, 1'b0, CTI_INCR,    3'b000, 3'b000, 1'b0, A0);
      add(1'b0, 3'b101, 1'b1, CTI_INCR,    3'b100, 3'b100, 1'b1, A2);
      add(1'b0, 3'b101, 1'b1, CTI_INCR,    3'b100, 3'b100, 1'b1, A2);
      add(1'b0, 3'b101, 1'b1, CTI_INCR,    3'b100, 3'b100, 1'b1, A2);
      add(1'b0, 3'b101, 1'b1, CTI_END,     3'b100, 3'b100, 1'b1, A2);
      add(1'b0, 3'b001, 1'b0, CTI_CLASSIC, 3'b100, 3'b000, 1'b0, A2);
      add(1'b0, 3'b001, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A2);
      add(1'b0, 3'b001, 1'b1, CTI_CLASSIC, 3'b001, 3'b001, 1'b1, A0);
      add(1'b0, 3'b000, 1'b0, CTI_CLASSIC, 3'b001, 3'b000, 1'b0, A0);
      add(1'b0, 3'b000, 1'b0, CTI_CLASSIC, 3'b000, 3'b000, 1'b0, A0);

      nxt();
      foreach (tbl[n]) begin
         wb_rst_i = tbl[n].rst; cyc = tbl[n].cyc; stb = tbl[n].cyc;
         s_ack = tbl[n].ack; cti[2] = tbl[n].cti2;
         #4;
         chk($sformatf("row%0d gnt", n), 64'(gnt), 64'(tbl[n].e_gnt));
         chk($sformatf("row%0d ack", n), 64'(ack), 64'(tbl[n].e_ack));
         chk($sformatf("row%0d wbs_cyc", n), 64'(wbs_cyc), 64'(tbl[n].e_cyc));
         chk($sformatf("row%0d wbs_adr", n), 64'(wbs_adr), 64'(tbl[n].e_adr));
         nxt();
      end

      // Watchdog: m0 stalls until err fires on the TO-th stalled cycle.
      cyc = 3'b001; stb = 3'b001; s_ack = 1'b0;
      #4; chk("wd idle gnt", 64'(gnt), 64'(3'b000)); nxt();
      for (int s = 1; s <= TO; s++) begin
         #4;
         chk($sformatf("wd stall%0d err", s), 64'(err), 64'((s == TO) ? 3'b001 : 3'b000));
         chk($sformatf("wd stall%0d wbs_cyc", s), 64'(wbs_cyc), 64'(1'b1));
         nxt();
      end
      s_ack = 1'b1;
      #4;
      chk("tmo term", 64'({ack, err}), 64'(6'b0));
      chk("tmo wbs_cyc", 64'({wbs_cyc, wbs_stb}), 64'(2'b00));
      chk("tmo gnt", 64'(gnt), 64'(3'b001));
      nxt();
      s_ack = 1'b0; cyc = 3'b000; stb = 3'b000;
      #4; chk("tmo drop gnt", 64'(gnt), 64'(3'b001)); nxt();
      #4; chk("tmo idle gnt", 64'(gnt), 64'(3'b000));

      // Ack on the limit cycle beats the watchdog and clears the count.
      cyc = 3'b001; stb = 3'b001;
      nxt();
      for (int s = 1; s <= TO; s++) begin
         s_ack = (s == TO);
         #4;
         chk($sformatf("race stall%0d err", s), 64'(err), 64'(3'b000));
         if (s == TO) chk("race ack", 64'(ack), 64'(3'b001));
         nxt();
      end
      s_ack = 1'b0;
      for (int s = 1; s < TO; s++) begin
         #4; chk($sformatf("race restall%0d err", s), 64'(err), 64'(3'b000)); nxt();
      end
      // Master leaves on the cycle the limit would hit: no err, back to idle.
      cyc = 3'b000;
      #4;
      chk("drop@limit err", 64'(err), 64'(3'b000));
      chk("drop@limit gnt", 64'(gnt), 64'(3'b001));
      nxt();
      stb = 3'b000;
      #4; chk("drop@limit idle gnt", 64'(gnt), 64'(3'b000)); nxt();

      // Reset in the middle of an m1 burst.
      cyc = 3'b010; stb = 3'b010; cti[1] = CTI_INCR;
      nxt();
      s_ack = 1'b1;
      #4; chk("burst m1 ack", 64'(ack), 64'(3'b010)); nxt();
      #2; wb_rst_i = 1'b1; #1;
      chk("rst mid-burst term", 64'({ack, err, rty}), 64'(9'b0));
      chk("rst mid-burst wbs", 64'({wbs_cyc, wbs_stb, wbs_we}), 64'(3'b000));
      chk("rst mid-burst gnt", 64'(gnt), 64'(3'b000));
      nxt();
      wb_rst_i = 1'b0; s_ack = 1'b0; cyc = 3'b011; stb = 3'b011; cti[1] = CTI_CLASSIC;
      #4; chk("post-rst c0 gnt", 64'(gnt), 64'(3'b000)); nxt();
      #4; chk("post-rst c1 gnt", 64'(gnt), 64'(3'b000)); nxt();
      #4; chk("post-rst c2 gnt", 64'(gnt), 64'(3'b001)); nxt();
      cyc = 3'b000; stb = 3'b000;
      nxt();

      // Random masters and slave against the reference model.
      wb_rst_i = 1'b1; mdl_reset();
      nxt();
      for (int c = 0; c < 4000; c++) begin
         rst_now  = ($urandom_range(0, 499) == 0);
         wb_rst_i = rst_now;
         for (int i = 0; i < 3; i++) begin
            if (cyc[ix(i)]) begin
               if (ttl[i] == 0) cyc[ix(i)] = 1'b0;
               else ttl[i]--;
            end else if ($urandom_range(0, 3) == 0) begin
               cyc[ix(i)] = 1'b1;
               ttl[i]     = int'($urandom_range(0, 24));
            end
            stb[ix(i)] = cyc[ix(i)] && ($urandom_range(0, 7) != 0);
            we[ix(i)]  = 1'($urandom);
            adr[ix(i)] = $urandom; dat[ix(i)] = $urandom;
            sel[ix(i)] = 4'($urandom); cti[ix(i)] = 3'($urandom); bte[ix(i)] = 2'($urandom);
         end
         quiet = ((c / 200) % 2) == 1;
         p     = quiet ? 3 : 40;
         r     = int'($urandom_range(0, 99));
         s_ack = (r < p);
         s_err = (r >= p) && (r < p + 4);
         s_rty = (r >= p + 4) && (r < p + 7);
         s_dat = $urandom;
         if (rst_now) mdl_reset();

         busy   = (mode == 1) && !rst_now;
         m_term = s_ack || s_err || s_rty;
         m_tmo  = busy && cyc[ix(gi)] && stb[ix(gi)] && !m_term && (cnt == TO - 1);
         oh     = 3'(1 << gi);
         e_gnt  = (mode != 0) ? oh : 3'b000;
         e_ack  = (busy && s_ack) ? oh : 3'b000;
         e_err  = (busy && (s_err || m_tmo)) ? oh : 3'b000;
         e_rty  = (busy && s_rty) ? oh : 3'b000;
         e_ctl  = busy ? {cyc[ix(gi)], stb[ix(gi)], we[ix(gi)]} : 3'b000;
         e_sel  = busy ? sel[ix(gi)] : 4'h0;
         src    = (mode != 0) ? gi : li;
         #4;
         chk($sformatf("rnd%0d gnt", c), 64'(gnt), 64'(e_gnt));
         chk($sformatf("rnd%0d term", c), 64'({ack, err, rty}), 64'({e_ack, e_err, e_rty}));
         chk($sformatf("rnd%0d wbs_ctl", c), 64'({wbs_cyc, wbs_stb, wbs_we, wbs_sel}), 64'({e_ctl, e_sel}));
         chk($sformatf("rnd%0d wbs_adr_dat", c), {wbs_adr, wbs_dat}, {adr[ix(src)], dat[ix(src)]});
         chk($sformatf("rnd%0d wbs_cti_bte", c), 64'({wbs_cti, wbs_bte}), 64'({cti[ix(src)], bte[ix(src)]}));
         chk($sformatf("rnd%0d rdat", c), 64'({mdat0, mdat1 ^ mdat2}), 64'({s_dat, 32'h0}));
         @(posedge wb_clk_i);
         if (!rst_now) mdl_step();
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arb3.md
WB_ARB3 -- requirements
Module: wb_arb3

Interface
REQ-001 Parameter dw, default 32, data width.
REQ-002 Parameter aw, default 32, address width.
REQ-003 Parameter to_cycles, default 255, watchdog limit in clock cycles; 0 disables watchdog.
REQ-004 wb_clk_i  input  1  clock; all logic on rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 wbmN_adr_i/dat_i/sel_i  input  aw/dw/dw/8  master N address, write data, byte selects (N=0..2).
REQ-007 wbmN_cyc_i/stb_i/we_i  input  1 each  master N cycle, strobe, write enable.
REQ-008 wbmN_cti_i/bte_i  input  3/2  master N burst cycle type and burst type.
REQ-009 wbmN_ack_o/err_o/rty_o  output  1 each  master N termination.
REQ-010 wbmN_dat_o  output  dw  master N read data.
REQ-011 wbs_adr_o/dat_o/sel_o  output  aw/dw/dw/8  slave address, write data, byte selects.
REQ-012 wbs_cyc_o/stb_o/we_o/cti_o/bte_o  output  1/1/1/3/2  slave control.
REQ-013 wbs_dat_i/ack_i/err_i/rty_i  input  dw/1/1/1  slave read data and terminations.
REQ-014 gnt_o  output  3  one-hot current grant, 0 when none; debug/status.

Function
REQ-015 FSM states IDLE, BUSY, TMO; encoding from shared package.
REQ-016 IDLE: if any wbmN_cyc_i high, grant registered at next edge to first requester in round-robin order starting after last grantee; state -> BUSY.
REQ-017 Arbitration latency: exactly one cycle from cyc high in IDLE to wbs_cyc_o high.
REQ-018 BUSY: all wbs_* outputs combinationally follow granted master; wbs_ack/err/rty_i routed only to granted master's ack/err/rty_o.
REQ-019 Grant held for whole cycle including bursts (cti 3'b001, 3'b010), independent of cti/bte values.
REQ-020 BUSY -> IDLE when granted master's cyc_i low; last grantee updated; one dead cycle before next grant.
REQ-021 Non-granted masters: ack_o, err_o, rty_o = 0 at all times.
REQ-022 wbmN_dat_o = wbs_dat_i for all N (broadcast).
REQ-023 IDLE/TMO: wbs_cyc_o, wbs_stb_o, wbs_we_o = 0; wbs_sel_o = 0; other wbs_* outputs from last grantee.
REQ-024 Watchdog counter width clog2(to_cycles+1); counts in BUSY while granted stb_i high and no slave ack/err/rty; cleared on any termination, on stb low, on leaving BUSY.
REQ-025 Counter reaching to_cycles: state -> TMO; granted master err_o high for exactly that one cycle, sourced internally; slave cyc/stb drop.
REQ-026 TMO -> IDLE when granted master cyc_i low; further stb in TMO gets no termination.
REQ-027 Termination and limit in same cycle: slave termination wins, counter clears, no TMO.
REQ-028 cyc_i low and limit in same cycle: go IDLE, no err_o.
REQ-029 to_cycles = 0: TMO unreachable.

Reset
REQ-030 Reset asserted: state IDLE, gnt_o 0, counter 0, last grantee = master 2 (master 0 first priority).
REQ-031 All wbm*_ack/err/rty_o and wbs_cyc/stb/we_o low immediately on reset assertion, including mid-burst.
REQ-032 First grant possible at second rising edge after reset deassertion.

Structure
REQ-033 Package wb_arb_pkg holds state encoding, cti constants (classic 3'b000, const 3'b001, incr 3'b010, end 3'b111), master count 3.
REQ-034 Sub-module wb_arb_rr_pick: combinational round-robin selector (3-bit request, 3-bit last one-hot -> 3-bit one-hot grant).

Verification
REQ-035 Only m1 cyc/stb, classic read adr 0x10 -> wbs_cyc_o high cycle 2, gnt_o=3'b010, slave ack -> wbm1_ack_o=1, wbm0/2 ack 0.
REQ-036 All three request continuously, 1-beat cycles -> grant order m0, m1, m2, m0; one dead cycle between grants.
REQ-037 m2 4-beat incr burst (cti 010,010,010,111) while m0 requests -> m0 waits until m2 cyc low, then granted.
REQ-038 to_cycles=8, slave never acks -> wbm0_err_o pulses once on 8th stalled cycle, wbs_cyc_o low after, IDLE after m0 drops cyc.
REQ-039 Slave ack on same cycle counter hits 8 -> ack_o only, err_o stays 0.
REQ-040 Reset pulse mid-burst of m1 -> outputs low immediately; after release m0 and m1 requesting -> m0 granted first.
